regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential read-back engine for the MIPS register file. On a start pulse it walks a contiguous, optionally wrapping, range of register indices through one register-file read port. It returns each word on a valid/ready stream tagged with its index, then pulses done. It reads back what the datapath wrote and serves debug dump, scan-out and self-check benches.

## Interface

Parameters:
- WORD_LENGTH, 32, data word width; matches the register file.
- NBITS, CeilLog2(WORD_LENGTH) = 5, register index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE without done.
- first_reg  in  NBITS  first index to dump; latched on accepted start.
- last_reg  in  NBITS  last index to dump; latched on accepted start.
- Read_Reg  out  NBITS  drives register-file read address.
- Read_Data  in  WORD_LENGTH  combinational read data from the register file.
- dump_data  out  WORD_LENGTH  captured word.
- dump_index  out  NBITS  index of dump_data.
- dump_valid  out  1  word available.
- dump_ready  in  1  consumer accepts; transfer = valid & ready at a rising edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last transfer.

## Operation

- States: IDLE, READ, HOLD, DONE.
- IDLE: busy=0, dump_valid=0. If start=1: latch last_reg, idx<=first_reg, go to READ.
- READ: Read_Reg=idx, held stable for the cycle. At the edge: dump_data<=Read_Data, dump_index<=idx, dump_valid<=1, go to HOLD.
- HOLD: dump_valid=1. dump_data and dump_index are frozen while ready=0.
  - On transfer with idx==last: dump_valid<=0, go to DONE.
  - On transfer otherwise: idx<=idx+1 modulo 2^NBITS, dump_valid<=0, go to READ.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- Word count = ((last_reg − first_reg) mod 2^NBITS) + 1.
  - first_reg==last_reg dumps exactly 1 word.
  - first_reg > last_reg wraps past 31 to 0, e.g. 30,31,0,1.
  - A full 32-word dump uses last_reg = first_reg − 1.
- start while busy is ignored; the latched range is not disturbed.
- abort=1 in any non-IDLE state: next state IDLE, dump_valid<=0, no done pulse. Any in-flight word is dropped.
- abort and start together in IDLE: abort wins, the engine stays in IDLE.
- Concurrent register-file writes are permitted. The captured word is Read_Data as sampled at the READ-cycle edge, with no bypass.
- Index register 0 is dumped like any other index; its value is whatever the register file returns.

## Timing

- Reset values: state IDLE, Read_Reg=0, dump_data=0, dump_index=0, dump_valid=0, busy=0, done=0, internal idx/last=0.
- Reset asserted mid-dump has the same effect as reset from power-up. Nothing is emitted afterwards until a new start.
- Latency: start sampled at edge N. Read_Reg=first_reg and busy=1 follow edge N. dump_valid=1 follows edge N+1.
- Throughput: 2 cycles per word with dump_ready held high (one READ cycle, one HOLD cycle).
- Last transfer at edge M: done=1 during the cycle after edge M. busy drops and a new start is accepted after edge M+1.
- All outputs are registered; none depends combinationally on dump_ready.

## Structure

- Shared MIPS package holds:
  - the WORD_LENGTH and NBITS defaults;
  - the CeilLog2 function, to be moved there and reused by the register file;
  - the state encoding localparams (IDLE=2'd0, READ=2'd1, HOLD=2'd2, DONE=2'd3).
- Single module with one FSM plus idx and last registers; no sub-module.
- The bench instantiates Register_File with its Read_Reg1/Read_Data1 port wired to Read_Reg/Read_Data. Its write port preloads contents.

## Test plan

- Preload reg k = k for all k. Start with first=5, last=10, ready=1 → indices 5..10 with data 5..10, one word every 2 cycles, done 1 cycle after the 6th transfer.
- first=30, last=1 → wrap order 30,31,0,1 with data 30,31,0,1, then done; exactly 4 words.
- first=last=7 with ready held 0 for 5 cycles → valid stays 1 and data 7 stays frozen; transfer on ready, then done.
- During a dump, at the cycle Read_Reg=12, write reg 12 = 32'hABABABAB → emitted word equals the value sampled at the READ edge; a later start 12..12 returns 32'hABABABAB.
- Assert abort in HOLD at index 3 of range 0..31 → valid drops next cycle, no done. A start pulse while busy earlier had no effect; a new start 0..0 works.
- Assert reset mid-dump (index 20) → all outputs 0 the next cycle, FSM in IDLE. A start 4..4 afterwards yields data 4.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared MIPS definitions.
//   WORD_LENGTH_DEFAULT / NBITS_DEFAULT : data word and register index widths
//   CeilLog2                            : index width for a given entry count
//   state_t                             : dump engine FSM encoding
package regfile_dump_pkg;
   localparam int WORD_LENGTH_DEFAULT = 32;
   function automatic int CeilLog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction
   localparam int NBITS_DEFAULT = CeilLog2(WORD_LENGTH_DEFAULT);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/register_file.sv
// Register_File: MIPS register file, one synchronous write port, two combinational read ports.
//   clk, reset                          : clock, synchronous active-high clear of all entries
//   Reg_Write, Write_Register, Write_Data : write port, takes effect at the rising edge
//   Read_Reg1/Read_Data1, Read_Reg2/Read_Data2 : read ports, no write bypass
module Register_File
   import regfile_dump_pkg::*;
#(
   parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
   parameter int NBITS = CeilLog2(WORD_LENGTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Reg_Write,
   input  logic [NBITS-1:0]       Write_Register,
   input  logic [WORD_LENGTH-1:0] Write_Data,
   input  logic [NBITS-1:0]       Read_Reg1,
   input  logic [NBITS-1:0]       Read_Reg2,
   output logic [WORD_LENGTH-1:0] Read_Data1,
   output logic [WORD_LENGTH-1:0] Read_Data2
);
   logic [WORD_LENGTH-1:0] regs [2**NBITS];
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**NBITS; i++) regs[i] <= '0;
      end else if (Reg_Write) begin
         regs[Write_Register] <= Write_Data;
      end
   end
   assign Read_Data1 = regs[Read_Reg1];
   assign Read_Data2 = regs[Read_Reg2];
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks a wrapping register index range through one read port and streams the words out.
//   clk, reset           : clock, synchronous active-high reset
//   start, abort         : begin a dump (IDLE only) / cancel without done
//   first_reg, last_reg  : inclusive index range, wraps modulo 2^NBITS
//   Read_Reg, Read_Data  : register-file read port
//   dump_data/dump_index/dump_valid/dump_ready : output word stream
//   busy, done           : engine active / one-cycle completion pulse
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
   parameter int NBITS = CeilLog2(WORD_LENGTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NBITS-1:0]       first_reg,
   input  logic [NBITS-1:0]       last_reg,
   output logic [NBITS-1:0]       Read_Reg,
   input  logic [WORD_LENGTH-1:0] Read_Data,
   output logic [WORD_LENGTH-1:0] dump_data,
   output logic [NBITS-1:0]       dump_index,
   output logic                   dump_valid,
   input  logic                   dump_ready,
   output logic                   busy,
   output logic                   done
);
   state_t           state, state_nx;
   logic [NBITS-1:0] idx, last;
   // idx is itself a register, so the read address stays stable for the whole READ cycle
   assign Read_Reg = idx;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         last       <= '0;
         dump_data  <= '0;
         dump_index <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == READ) begin
            idx  <= first_reg;
            last <= last_reg;
         end
         if (state == READ && state_nx == HOLD) begin
            dump_data  <= Read_Data;
            dump_index <= idx;
         end
         if (state == HOLD && state_nx == READ) idx <= idx + 1'b1;
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = start ? READ : IDLE;
         READ: state_nx = HOLD;
         HOLD: state_nx = dump_ready ? ((idx == last) ? DONE : READ) : HOLD;
         DONE: state_nx = IDLE;
      endcase
      // abort overrides everything, including a start arriving in IDLE
      if (abort) state_nx = IDLE;
      busy       = state != IDLE;
      dump_valid = state == HOLD;
      done       = state == DONE;
   end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed and randomized checks of regfile_dump against a shadow-memory model.
module tb_regfile_dump;
   import regfile_dump_pkg::*;
   localparam int W = WORD_LENGTH_DEFAULT;
   localparam int N = NBITS_DEFAULT;
   logic clk = 0;
   logic reset, rf_reset, start, abort, dump_ready, dump_valid, busy, done, wr_en;
   logic [N-1:0] first_reg, last_reg, Read_Reg, dump_index, wr_addr;
   logic [W-1:0] Read_Data, dump_data, wr_data, rd2;
   logic [W-1:0] mem [32];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   regfile_dump #(.WORD_LENGTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg), .Read_Reg(Read_Reg), .Read_Data(Read_Data),
      .dump_data(dump_data), .dump_index(dump_index), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .busy(busy), .done(done)
   );
   Register_File #(.WORD_LENGTH(W)) rf (
      .clk(clk), .reset(rf_reset), .Reg_Write(wr_en), .Write_Register(wr_addr),
      .Write_Data(wr_data), .Read_Reg1(Read_Reg), .Read_Reg2(5'd0),
      .Read_Data1(Read_Data), .Read_Data2(rd2)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic rf_write(input logic [N-1:0] a, input logic [W-1:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 0;
      mem[a] = d;
   endtask
   // Model: words are mem[first], mem[first+1], ... (mod 32), ((last-first) mod 32)+1 of them
   task automatic run_dump(input logic [N-1:0] f, input logic [N-1:0] l, input int smin, input int smax,
                           input int wr_idx, input logic [W-1:0] wr_val);
      logic [N-1:0] d, e;
      logic [W-1:0] exp;
      int n, w, s;
      d = l - f;
      n = int'(d) + 1;
      first_reg = f; last_reg = l; start = 1;
      tick();
      start = 0;
      chk("lat_busy", busy, 1);
      chk("lat_read_reg", Read_Reg, f);
      chk("lat_valid", dump_valid, 0);
      for (int i = 0; i < n; i++) begin
         e = f + N'(i);
         exp = mem[e];
         chk("read_reg", Read_Reg, e);
         if (int'(e) == wr_idx) begin
            wr_en = 1; wr_addr = e; wr_data = wr_val;
         end
         tick();
         wr_en = 0;
         w = 1;
         while (!dump_valid && w < 8) begin
            tick();
            w++;
         end
         if (int'(e) == wr_idx) mem[e] = wr_val;
         chk("valid", dump_valid, 1);
         chk("word_latency", w, 1);
         chk("index", dump_index, e);
         chk("data", dump_data, exp);
         chk("no_done_mid", done, 0);
         s = $urandom_range(smax, smin);
         dump_ready = 0;
         repeat (s) begin
            tick();
            chk("stall_valid", dump_valid, 1);
            chk("stall_index", dump_index, e);
            chk("stall_data", dump_data, exp);
         end
         dump_ready = 1;
         tick();
         dump_ready = 0;
         chk("valid_drop", dump_valid, 0);
         chk("done_after", done, (i == n - 1) ? 1 : 0);
         chk("busy_after", busy, 1);
      end
      tick();
      chk("done_pulse_end", done, 0);
      chk("idle_busy", busy, 0);
   endtask
   initial begin
      int seen[$];
      int g;
      logic found;
      reset = 1; rf_reset = 1; start = 0; abort = 0; dump_ready = 0;
      first_reg = 0; last_reg = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
      tick(); tick();
      reset = 0; rf_reset = 0;
      chk("rst_read_reg", Read_Reg, 0);
      chk("rst_data", dump_data, 0);
      chk("rst_index", dump_index, 0);
      chk("rst_valid", dump_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      for (int k = 0; k < 32; k++) rf_write(N'(k), W'(k));
      run_dump(5, 10, 0, 0, -1, 0);
      run_dump(30, 1, 0, 0, -1, 0);
      run_dump(7, 7, 5, 5, -1, 0);
      run_dump(10, 14, 0, 1, 12, 32'hABABABAB);
      run_dump(12, 12, 0, 0, -1, 0);
      chk("write_landed", dump_data, 32'hABABABAB);
      // abort together with start in IDLE keeps the engine idle
      first_reg = 2; last_reg = 2; start = 1; abort = 1;
      tick();
      start = 0; abort = 0;
      chk("abort_start_idle", busy, 0);
      tick();
      chk("abort_start_valid", dump_valid, 0);
      // abort in HOLD at index 3 of 0..31, with an ignored start while busy
      first_reg = 0; last_reg = 31; start = 1;
      tick();
      start = 0; dump_ready = 1; g = 0;
      while (g < 40) begin
         if (g == 2) begin first_reg = 9; last_reg = 9; start = 1; end
         tick();
         start = 0;
         g++;
         if (dump_valid) begin
            seen.push_back(int'(dump_index));
            if (dump_index == 3) break;
         end
      end
      chk("abort_seen_count", seen.size(), 4);
      foreach (seen[i]) chk("abort_seen_order", seen[i], i);
      abort = 1; dump_ready = 0;
      tick();
      abort = 0;
      chk("abort_valid", dump_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (3) begin
         tick();
         chk("abort_no_done", done, 0);
         chk("abort_no_valid", dump_valid, 0);
      end
      run_dump(0, 0, 0, 0, -1, 0);
      // reset mid-dump at index 20
      first_reg = 15; last_reg = 25; start = 1;
      tick();
      start = 0; dump_ready = 1; found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         found = dump_valid && dump_index == 20;
      end
      chk("reset_reached_20", found, 1);
      reset = 1; dump_ready = 0;
      tick();
      chk("mid_rst_read_reg", Read_Reg, 0);
      chk("mid_rst_data", dump_data, 0);
      chk("mid_rst_index", dump_index, 0);
      chk("mid_rst_valid", dump_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      reset = 0;
      repeat (3) begin
         tick();
         chk("post_rst_quiet", {dump_valid, busy, done}, 0);
      end
      run_dump(4, 4, 0, 0, -1, 0);
      chk("post_rst_data4", dump_data, 4);
      // full 32-word dump with wrap
      run_dump(17, 16, 0, 1, -1, 0);
      // randomized contents, ranges and back-pressure
      repeat (6) begin
         repeat (3) rf_write(N'($urandom_range(31, 0)), $urandom);
         run_dump(N'($urandom_range(31, 0)), N'($urandom_range(31, 0)), 0, 2, -1, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
